freq_counter_bcd: RTL

- Gated frequency counter that feeds the per-digit 7-segment decoders of the frequency meter.
- Counts rising edges of an asynchronous input over a fixed gate window of GATE_CYCLES clocks.
- Counts in cascaded BCD digits and latches the result once per window as a packed BCD word, one nibble per display digit.

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/bcd_digit_counter.sv | 25 ++
 rtl/freq_counter_bcd.sv | 133 +++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated BCD frequency counter.
package freq_meter_pkg;

    localparam int              DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic {IDLE, COUNT} state_e;

    // Next value of one BCD digit; saturation wins over counting.
    function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] q,
                                                    input logic inc,
                                                    input logic sat);
        if (sat) return BCD_MAX;
        if (inc) return (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        return q;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade of the cascaded BCD counter: wraps 9->0 with carry, holds 9 when saturated.
module bcd_digit_counter
    import freq_meter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    input  logic               sat,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (!rst_n)   q_q <= '0;
        else if (clr) q_q <= '0;
        else          q_q <= bcd_next(q_q, inc, sat);
    end

    assign q     = q_q;
    assign carry = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/freq_counter_bcd.sv
// Gated frequency counter: counts sig_in rising edges per GATE_CYCLES window into packed BCD.
// Optional FREQ_LEADING_ZERO_BLANK_EN replaces leading zero digits with BLANK_CODE at latch time.
module freq_counter_bcd
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int NUM_DIGITS  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          sig_in,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
    output logic                          valid,
    output logic                          overflow,
    output logic                          gate_active
);

    localparam int              GC_W      = $clog2(GATE_CYCLES);
    localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES - 1);

    logic sync1_q, sync2_q, prev_q, edge_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_w = sync2_q & ~prev_q;

    state_e          state_q, state_d;
    logic [GC_W-1:0] gate_cnt_q, gate_cnt_d;
    logic            flag_q, flag_d;
    logic            terminal_w, clr_w, sat_w;
    logic [NUM_DIGITS:0]                    inc_w;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     dig_q, dig_nxt, lat_w;

    assign terminal_w = (state_q == COUNT) && (gate_cnt_q == GATE_LAST);
    assign clr_w      = (state_q != COUNT) || terminal_w || !en;
    assign inc_w[0]   = edge_w & (state_q == COUNT) & ~flag_q;
    // Carry out of the top digit saturates the chain in the same cycle.
    assign sat_w      = flag_q | inc_w[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit_counter u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_w),
            .inc   (inc_w[i]),
            .sat   (sat_w),
            .q     (dig_q[i]),
            .carry (inc_w[i+1])
        );
        assign dig_nxt[i] = bcd_next(dig_q[i], inc_w[i], sat_w);
    end

`ifdef FREQ_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen;
        lat_w = dig_nxt;
        seen  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (!seen && dig_nxt[i] == '0) lat_w[i] = BLANK_CODE;
            else                           seen     = 1'b1;
        end
    end
`else
    assign lat_w = dig_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            flag_q     <= flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = '0;
        flag_d     = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = COUNT;
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!terminal_w) begin
                    gate_cnt_d = gate_cnt_q + GC_W'(1);
                    flag_d     = sat_w;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gate_active = (state_q == COUNT);
    end

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_q;
    logic                               valid_q, ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= terminal_w;
            if (terminal_w) begin
                bcd_q <= lat_w;
                ovf_q <= sat_w;
            end
        end
    end

    assign bcd_out  = bcd_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule
